// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and destination scoreboard for the single-write-port register file.
// Round-robin shares the write port among NREQ producers; the busy bitmap lets decode stall on RAW/WAW.
module rf_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid_i,
   input  logic [NREQ*AW-1:0]   req_rd_i,
   input  logic [NREQ*XLEN-1:0] req_wd_i,
   output logic [NREQ-1:0]      req_ready_o,
   input  logic                 rsv_valid_i,
   input  logic [AW-1:0]        rsv_rd_i,
   output logic                 rsv_ready_o,
   input  logic [AW-1:0]        chk_rs1_i,
   input  logic [AW-1:0]        chk_rs2_i,
   output logic                 rs1_busy_o,
   output logic                 rs2_busy_o,
   output logic                 rf_we_o,
   output logic [AW-1:0]        rf_rd_o,
   output logic [XLEN-1:0]      rf_wd_o,
   output logic [(1<<AW)-1:0]   busy_mask_o,
   output logic                 err_unreserved_o
);

   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int NREG = 1 << AW;

   logic [PW-1:0]   ptr_q, ptr_d;
   logic [NREG-1:0] busy_q, busy_d;
   logic            rfWe_q, rfWe_d;
   logic [AW-1:0]   rfRd_q, rfRd_d;
   logic [XLEN-1:0] rfWd_q, rfWd_d;
   logic            err_q, err_d;

   logic [NREQ-1:0] grant;
   logic [PW-1:0]   grantIdx;
   logic            xfer;
   logic [PW:0]     scanSum;
   logic [PW-1:0]   scanIdx;
   logic [AW-1:0]   selRd;
   logic [XLEN-1:0] selWd;
   logic            rsvAccept;

   // Rotating priority scan: the first valid requester at or after the pointer wins.
   always_comb begin
      grant    = '0;
      grantIdx = '0;
      xfer     = 1'b0;
      scanSum  = '0;
      scanIdx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         scanSum = {1'b0, ptr_q} + (PW+1)'(k);
         if (scanSum >= (PW+1)'(NREQ)) begin
            scanSum = scanSum - (PW+1)'(NREQ);
         end
         scanIdx = scanSum[PW-1:0];
         if (!xfer && req_valid_i[scanIdx]) begin
            grant[scanIdx] = 1'b1;
            grantIdx       = scanIdx;
            xfer           = 1'b1;
         end
      end
      if (reset) begin
         grant = '0;
         xfer  = 1'b0;
      end
   end

   assign req_ready_o = grant;
   assign selRd       = req_rd_i[int'(grantIdx)*AW +: AW];
   assign selWd       = req_wd_i[int'(grantIdx)*XLEN +: XLEN];

   // A destination can only be reserved again once its previous write has committed (WAW stall).
   assign rsv_ready_o = (rsv_rd_i == '0) || !busy_q[rsv_rd_i];
   assign rsvAccept   = rsv_valid_i && rsv_ready_o;

   always_comb begin
      ptr_d  = ptr_q;
      rfWe_d = 1'b0;
      rfRd_d = rfRd_q;
      rfWd_d = rfWd_q;
      err_d  = err_q;
      busy_d = busy_q;
      if (xfer) begin
         ptr_d  = (grantIdx == PW'(NREQ-1)) ? '0 : grantIdx + PW'(1);
         rfWe_d = (selRd != '0);
         rfRd_d = selRd;
         rfWd_d = selWd;
         if ((selRd != '0) && (!busy_q[selRd] || (rfWe_q && rfRd_q == selRd))) begin
            err_d = 1'b1;
         end
      end
      // Clear lands with the register file commit; a set in the same cycle wins.
      if (rfWe_q) begin
         busy_d[rfRd_q] = 1'b0;
      end
      if (rsvAccept && (rsv_rd_i != '0)) begin
         busy_d[rsv_rd_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q  <= '0;
         busy_q <= '0;
         rfWe_q <= 1'b0;
         rfRd_q <= '0;
         rfWd_q <= '0;
         err_q  <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         busy_q <= busy_d;
         rfWe_q <= rfWe_d;
         rfRd_q <= rfRd_d;
         rfWd_q <= rfWd_d;
         err_q  <= err_d;
      end
   end

   // The register file forwards write data, so a source committing this cycle is already readable.
   assign rs1_busy_o = (chk_rs1_i != '0) && busy_q[chk_rs1_i] && !(rfWe_q && rfRd_q == chk_rs1_i);
   assign rs2_busy_o = (chk_rs2_i != '0) && busy_q[chk_rs2_i] && !(rfWe_q && rfRd_q == chk_rs2_i);

   assign rf_we_o          = rfWe_q;
   assign rf_rd_o          = rfRd_q;
   assign rf_wd_o          = rfWd_q;
   assign busy_mask_o      = busy_q;
   assign err_unreserved_o = err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model of grants, scoreboard and writes.
module tb_rf_wb_arbiter;

   localparam int NREQ = 3;
   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [NREQ-1:0]      reqValid = '0;
   logic [NREQ*AW-1:0]   reqRd = '0;
   logic [NREQ*XLEN-1:0] reqWd = '0;
   logic                 rsvValid = 1'b0;
   logic [AW-1:0]        rsvRd = '0;
   logic [AW-1:0]        chkRs1 = '0;
   logic [AW-1:0]        chkRs2 = '0;

   logic [NREQ-1:0]      reqReady;
   logic                 rsvReady;
   logic                 rs1Busy, rs2Busy;
   logic                 rfWe;
   logic [AW-1:0]        rfRd;
   logic [XLEN-1:0]      rfWd;
   logic [31:0]          busyMask;
   logic                 errUnreserved;

   int compareCount = 0;
   int failCount    = 0;

   always #5 clk = ~clk;

   rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
      .clk(clk),
      .reset(reset),
      .req_valid_i(reqValid),
      .req_rd_i(reqRd),
      .req_wd_i(reqWd),
      .req_ready_o(reqReady),
      .rsv_valid_i(rsvValid),
      .rsv_rd_i(rsvRd),
      .rsv_ready_o(rsvReady),
      .chk_rs1_i(chkRs1),
      .chk_rs2_i(chkRs2),
      .rs1_busy_o(rs1Busy),
      .rs2_busy_o(rs2Busy),
      .rf_we_o(rfWe),
      .rf_rd_o(rfRd),
      .rf_wd_o(rfWd),
      .busy_mask_o(busyMask),
      .err_unreserved_o(errUnreserved)
   );

   // Behavioural model: a set of reserved registers, a pending write, a pointer and a sticky flag.
   bit          mBusy[32];
   int          mPtr;
   bit          mWe;
   int          mRd;
   logic [31:0] mWd;
   bit          mErr;
   bit          modelLive = 1'b0;
   logic [NREQ-1:0] prevValid = '0;
   logic [NREQ-1:0] prevGrant = '0;
   bit          prevRst = 1'b1;

   function automatic int modelGrant();
      if (reset) return -1;
      for (int k = 0; k < NREQ; k++) begin
         int idx = (mPtr + k) % NREQ;
         if (reqValid[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [31:0] modelMask();
      logic [31:0] m = '0;
      for (int i = 1; i < 32; i++) m[i] = mBusy[i];
      return m;
   endfunction

   function automatic bit modelSrcBusy(input int a);
      return (a != 0) && mBusy[a] && !(mWe && mRd == a);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compareCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model advances on each edge from the inputs that were stable during the finished cycle.
   always @(posedge clk) begin
      int g;
      int rd;
      bit bitWasSet;
      bit clashes;
      g = modelGrant();
      for (int i = 0; i < NREQ; i++) begin
         if (!reset && !prevRst && prevValid[i] && !prevGrant[i] && !reqValid[i])
            $error("[TB] requester %0d dropped valid before ready", i);
      end
      prevValid = reqValid;
      prevGrant = (g >= 0) ? NREQ'(1 << g) : '0;
      prevRst   = reset;
      if (reset) begin
         for (int i = 0; i < 32; i++) mBusy[i] = 1'b0;
         mPtr = 0;
         mWe  = 1'b0;
         mRd  = 0;
         mWd  = '0;
         mErr = 1'b0;
      end else begin
         rd = (g >= 0) ? int'(reqRd[g*AW +: AW]) : 0;
         bitWasSet = mBusy[rd];
         clashes   = mWe && (mRd == rd);
         if (mWe) mBusy[mRd] = 1'b0;
         if (rsvValid && (rsvRd == 0 || !bitWasSetFor(rsvRd)) && rsvRd != 0) mBusy[rsvRd] = 1'b1;
         if (g >= 0) begin
            if (rd != 0 && (!bitWasSet || clashes)) mErr = 1'b1;
            mWe  = (rd != 0);
            mRd  = rd;
            mWd  = reqWd[g*XLEN +: XLEN];
            mPtr = (g + 1) % NREQ;
         end else begin
            mWe = 1'b0;
         end
      end
      modelLive = 1'b1;
   end

   // Reservation acceptance must look at the reservations as they stood before this edge.
   bit busySnap[32];
   always @(negedge clk) for (int i = 0; i < 32; i++) busySnap[i] = mBusy[i];
   function automatic bit bitWasSetFor(input int a);
      return busySnap[a];
   endfunction

   always @(negedge clk) begin
      if (modelLive) begin
         int g;
         g = modelGrant();
         checkOutput("req_ready", 32'(reqReady), (g >= 0) ? 32'(1 << g) : 32'd0);
         checkOutput("rsv_ready", 32'(rsvReady), 32'((rsvRd == 0) || !mBusy[rsvRd]));
         checkOutput("rs1_busy", 32'(rs1Busy), 32'(modelSrcBusy(int'(chkRs1))));
         checkOutput("rs2_busy", 32'(rs2Busy), 32'(modelSrcBusy(int'(chkRs2))));
         checkOutput("rf_we", 32'(rfWe), 32'(mWe));
         if (mWe) begin
            checkOutput("rf_rd", 32'(rfRd), 32'(mRd));
            checkOutput("rf_wd", rfWd, mWd);
         end
         checkOutput("busy_mask", busyMask, modelMask());
         checkOutput("err_unreserved", 32'(errUnreserved), 32'(mErr));
      end
   end

   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic doReset();
      reset    = 1'b1;
      reqValid = '0;
      rsvValid = 1'b0;
      applyStimulus(1);
      reset = 1'b0;
   endtask

   task automatic reserve(input int r);
      rsvValid = 1'b1;
      rsvRd    = AW'(r);
      applyStimulus(1);
      rsvValid = 1'b0;
   endtask

   task automatic present(input int i, input int rd, input logic [31:0] wd);
      reqValid[i]            = 1'b1;
      reqRd[i*AW +: AW]      = AW'(rd);
      reqWd[i*XLEN +: XLEN]  = wd;
   endtask

   logic [NREQ-1:0] readySnap;

   initial begin
      applyStimulus(2);
      reset = 1'b0;

      // Idle after reset
      repeat (5) begin
         @(negedge clk);
         checkOutput("idle rf_we", 32'(rfWe), 32'd0);
         checkOutput("idle busy_mask", busyMask, 32'd0);
         checkOutput("idle req_ready", 32'(reqReady), 32'd0);
         checkOutput("idle err", 32'(errUnreserved), 32'd0);
      end
      applyStimulus(1);

      // Reserve x5 then ALU writes it back
      reserve(5);
      present(0, 5, 32'hDEADBEEF);
      @(negedge clk);
      checkOutput("x5 grant", 32'(reqReady), 32'h1);
      checkOutput("x5 busy in T", busyMask, 32'h20);
      applyStimulus(1);
      reqValid[0] = 1'b0;
      chkRs1 = 5'd5;
      @(negedge clk);
      checkOutput("x5 rf_we", 32'(rfWe), 32'd1);
      checkOutput("x5 rf_rd", 32'(rfRd), 32'd5);
      checkOutput("x5 rf_wd", rfWd, 32'hDEADBEEF);
      checkOutput("x5 busy in T+1", busyMask, 32'h20);
      checkOutput("x5 rs1 forward", 32'(rs1Busy), 32'd0);
      applyStimulus(1);
      @(negedge clk);
      checkOutput("x5 busy after", busyMask, 32'd0);
      applyStimulus(1);
      chkRs1 = '0;

      // Round-robin with all three requesters
      doReset();
      for (int r = 1; r <= 3; r++) reserve(r);
      for (int i = 0; i < NREQ; i++) present(i, i + 1, 32'(32'h111 * (i + 1)));
      for (int k = 0; k < NREQ; k++) begin
         @(negedge clk);
         checkOutput("rr order", 32'(reqReady), 32'(1 << k));
         applyStimulus(1);
         reqValid[k] = 1'b0;
      end
      applyStimulus(2);
      for (int r = 1; r <= 3; r++) reserve(r);
      present(0, 1, 32'hA1);
      present(2, 3, 32'hA3);
      @(negedge clk);
      checkOutput("rr wrap 0", 32'(reqReady), 32'h1);
      applyStimulus(1);
      reqValid[0] = 1'b0;
      @(negedge clk);
      checkOutput("rr wrap 2", 32'(reqReady), 32'h4);
      applyStimulus(1);
      reqValid[2] = 1'b0;

      // WAW stall on x7 until its commit has happened
      doReset();
      reserve(7);
      rsvValid = 1'b1;
      rsvRd    = 5'd7;
      present(1, 7, 32'h77);
      @(negedge clk);
      checkOutput("waw stall T", 32'(rsvReady), 32'd0);
      checkOutput("waw grant", 32'(reqReady), 32'h2);
      applyStimulus(1);
      reqValid[1] = 1'b0;
      @(negedge clk);
      checkOutput("waw stall commit", 32'(rsvReady), 32'd0);
      checkOutput("waw rf_we", 32'(rfWe), 32'd1);
      applyStimulus(1);
      @(negedge clk);
      checkOutput("waw released", 32'(rsvReady), 32'd1);
      checkOutput("waw cleared", busyMask, 32'd0);
      applyStimulus(1);
      rsvRd = '0;
      @(negedge clk);
      checkOutput("rsv x0 ready", 32'(rsvReady), 32'd1);
      checkOutput("rsv x7 again", busyMask, 32'h80);
      applyStimulus(1);
      rsvValid = 1'b0;
      @(negedge clk);
      checkOutput("rsv x0 no set", busyMask, 32'h80);
      applyStimulus(1);

      // Unreserved write is flagged and sticky; a write to x0 is silent
      doReset();
      present(1, 9, 32'h12345678);
      @(negedge clk);
      checkOutput("unrsv grant", 32'(reqReady), 32'h2);
      applyStimulus(1);
      reqValid = '0;
      @(negedge clk);
      checkOutput("unrsv rf_we", 32'(rfWe), 32'd1);
      checkOutput("unrsv rf_rd", 32'(rfRd), 32'd9);
      checkOutput("unrsv err", 32'(errUnreserved), 32'd1);
      applyStimulus(3);
      @(negedge clk);
      checkOutput("err sticky", 32'(errUnreserved), 32'd1);
      applyStimulus(1);
      doReset();
      present(0, 0, 32'hAA);
      @(negedge clk);
      checkOutput("x0 grant", 32'(reqReady), 32'h1);
      applyStimulus(1);
      reqValid = '0;
      @(negedge clk);
      checkOutput("x0 rf_we", 32'(rfWe), 32'd0);
      checkOutput("x0 err", 32'(errUnreserved), 32'd0);
      applyStimulus(1);

      // Reset while requester 2 waits on a reserved x4
      doReset();
      reserve(4);
      reserve(6);
      reset = 1'b1;
      present(2, 4, 32'h44);
      @(negedge clk);
      checkOutput("rst no grant", 32'(reqReady), 32'd0);
      applyStimulus(1);
      @(negedge clk);
      checkOutput("rst busy", busyMask, 32'd0);
      checkOutput("rst rf_we", 32'(rfWe), 32'd0);
      applyStimulus(1);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("post rst grant", 32'(reqReady), 32'h4);
      applyStimulus(1);
      reqValid = '0;
      @(negedge clk);
      checkOutput("post rst err", 32'(errUnreserved), 32'd1);
      checkOutput("post rst rf_rd", 32'(rfRd), 32'd4);
      applyStimulus(1);

      // Randomized traffic against the model
      doReset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         readySnap = reqReady;
         applyStimulus(1);
         if ($urandom_range(0, 59) == 0) begin
            reset    = 1'b1;
            reqValid = '0;
         end else begin
            reset = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
               if (reqValid[i] && readySnap[i]) reqValid[i] = 1'b0;
               if (!reqValid[i] && $urandom_range(0, 2) == 0)
                  present(i, int'($urandom_range(0, 7)), $urandom);
            end
         end
         rsvValid = 1'($urandom_range(0, 1));
         rsvRd    = AW'($urandom_range(0, 7));
         chkRs1   = AW'($urandom_range(0, 7));
         chkRs2   = AW'($urandom_range(0, 7));
      end
      reset = 1'b0;
      applyStimulus(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
